// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-direction intersection light sequencer with pedestrian and emergency override
module traffic_light_ctrl #(
    parameter logic [31:0] CLK_DIV     = 32'd2000,
    parameter logic [4:0]  GREEN_TIME  = 5'd16,
    parameter logic [4:0]  YELLOW_TIME = 5'd3,
    parameter logic [4:0]  ALLRED_TIME = 5'd2,
    parameter logic [4:0]  PED_TIME    = 5'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [4:0] countdown_time,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        ALLRED_B,
        EW_GREEN,
        EW_YELLOW,
        ALLRED_A,
        EMERG
    } state_t;

    // Light encoding is {red, yellow, green}.
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    state_t      state;
    state_t      state_next;
    logic [31:0] div_cnt;
    logic [31:0] div_next;
    logic [4:0]  cd_next;
    logic        ped_next;
    logic [2:0]  ns_next;
    logic [2:0]  ew_next;
    logic        tick;
    logic        in_green;
    logic        yellow_entry;

    function automatic state_t succ_of(input state_t s);
        case (s)
            NS_GREEN:  succ_of = NS_YELLOW;
            NS_YELLOW: succ_of = ALLRED_B;
            ALLRED_B:  succ_of = EW_GREEN;
            EW_GREEN:  succ_of = EW_YELLOW;
            EW_YELLOW: succ_of = ALLRED_A;
            default:   succ_of = NS_GREEN;
        endcase
    endfunction

    function automatic logic [4:0] dur_of(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   dur_of = GREEN_TIME;
            NS_YELLOW, EW_YELLOW: dur_of = YELLOW_TIME;
            ALLRED_A, ALLRED_B:   dur_of = ALLRED_TIME;
            default:              dur_of = 5'd0;
        endcase
    endfunction

    assign tick     = (div_cnt == CLK_DIV - 32'd1);
    assign in_green = (state == NS_GREEN) || (state == EW_GREEN);

    always_comb begin
        state_next = state;
        cd_next    = countdown_time;
        ped_next   = ped_pending;
        div_next   = div_cnt;

        if (emergency) begin
            // Override wins over tick and any pending pedestrian request.
            state_next = EMERG;
            cd_next    = 5'd0;
            div_next   = 32'd0;
            ped_next   = 1'b0;
        end else if (state == EMERG) begin
            // Prescaler stays at 0 so the clearance phase is a full ALLRED_TIME from exit.
            state_next = ALLRED_A;
            cd_next    = ALLRED_TIME;
            div_next   = 32'd0;
            ped_next   = ped_req;
        end else begin
            div_next = tick ? 32'd0 : div_cnt + 32'd1;
            if (tick) begin
                if (in_green && ped_pending && (countdown_time > PED_TIME)) begin
                    cd_next = PED_TIME;
                end else if (countdown_time == 5'd1) begin
                    state_next = succ_of(state);
                    cd_next    = dur_of(succ_of(state));
                end else begin
                    cd_next = countdown_time - 5'd1;
                end
            end
            if (ped_req) begin
                ped_next = 1'b1;
            end else if (yellow_entry) begin
                ped_next = 1'b0;
            end
        end
    end

    assign yellow_entry = (state_next != state) &&
                          ((state_next == NS_YELLOW) || (state_next == EW_YELLOW));

    always_comb begin
        ns_next = RED;
        ew_next = RED;
        case (state_next)
            NS_GREEN:  ns_next = GREEN;
            NS_YELLOW: ns_next = YELLOW;
            EW_GREEN:  ew_next = GREEN;
            EW_YELLOW: ew_next = YELLOW;
            default: begin
                ns_next = RED;
                ew_next = RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= NS_GREEN;
            div_cnt        <= 32'd0;
            countdown_time <= GREEN_TIME;
            ns_light       <= GREEN;
            ew_light       <= RED;
            ped_pending    <= 1'b0;
        end else begin
            state          <= state_next;
            div_cnt        <= div_next;
            countdown_time <= cd_next;
            ns_light       <= ns_next;
            ew_light       <= ew_next;
            ped_pending    <= ped_next;
        end
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ped_req;
    logic       emergency;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [4:0] countdown_time;
    logic       ped_pending;

    int n_checks = 0;
    int n_pass   = 0;

    int         dur[6]    = '{16, 3, 2, 16, 3, 2};
    logic [2:0] ns_exp[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_exp[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    traffic_light_ctrl #(
        .CLK_DIV(32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ped_req        (ped_req),
        .emergency      (emergency),
        .ns_light       (ns_light),
        .ew_light       (ew_light),
        .countdown_time (countdown_time),
        .ped_pending    (ped_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        ped_req   = 1'b0;
        emergency = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        ped_req   = 1'b0;
        emergency = 1'b0;
        #12;
        check("rst_ns", 32'(ns_light), 32'h1);
        check("rst_ew", 32'(ew_light), 32'h4);
        check("rst_cd", 32'(countdown_time), 32'd16);
        check("rst_pp", 32'(ped_pending), 32'd0);

        // Full idle cycle, every clock checked against the duration table
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int c = dur[s]; c >= 1; c--) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("idle_cd_s%0d", s), 32'(countdown_time), 32'(c));
                    check($sformatf("idle_ns_s%0d", s), 32'(ns_light), 32'(ns_exp[s]));
                    check($sformatf("idle_ew_s%0d", s), 32'(ew_light), 32'(ew_exp[s]));
                    check("onehot_ns", 32'($countones(ns_light)), 32'd1);
                    check("onehot_ew", 32'($countones(ew_light)), 32'd1);
                    step(1);
                end
            end
        end
        check("wrap_cd", 32'(countdown_time), 32'd16);
        check("wrap_ns", 32'(ns_light), 32'h1);

        // Pedestrian request shortens NS green
        do_reset();
        step(10);
        check("ped1_cd10", 32'(countdown_time), 32'd14);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        check("ped1_pp11", 32'(ped_pending), 32'd1);
        check("ped1_cd11", 32'(countdown_time), 32'd14);
        step(1);
        check("ped1_cd12", 32'(countdown_time), 32'd5);
        step(19);
        check("ped1_cd31", 32'(countdown_time), 32'd1);
        check("ped1_pp31", 32'(ped_pending), 32'd1);
        check("ped1_ns31", 32'(ns_light), 32'h1);
        step(1);
        check("ped1_ns32", 32'(ns_light), 32'h2);
        check("ped1_cd32", 32'(countdown_time), 32'd3);
        check("ped1_pp32", 32'(ped_pending), 32'd0);

        // Request late in EW green: no reload
        step(72);
        check("ped2_ew104", 32'(ew_light), 32'h1);
        check("ped2_cd104", 32'(countdown_time), 32'd3);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        check("ped2_pp105", 32'(ped_pending), 32'd1);
        step(3);
        check("ped2_cd108", 32'(countdown_time), 32'd2);
        step(4);
        check("ped2_cd112", 32'(countdown_time), 32'd1);
        check("ped2_pp112", 32'(ped_pending), 32'd1);
        step(4);
        check("ped2_ew116", 32'(ew_light), 32'h2);
        check("ped2_ns116", 32'(ns_light), 32'h4);
        check("ped2_cd116", 32'(countdown_time), 32'd3);
        check("ped2_pp116", 32'(ped_pending), 32'd0);

        // Emergency during EW green, 20 cycles
        do_reset();
        step(90);
        check("emg_ew90", 32'(ew_light), 32'h1);
        emergency = 1'b1;
        step(1);
        check("emg_ns91", 32'(ns_light), 32'h4);
        check("emg_ew91", 32'(ew_light), 32'h4);
        check("emg_cd91", 32'(countdown_time), 32'd0);
        step(9);
        check("emg_cd100", 32'(countdown_time), 32'd0);
        step(10);
        check("emg_cd110", 32'(countdown_time), 32'd0);
        emergency = 1'b0;
        step(1);
        check("emg_cd111", 32'(countdown_time), 32'd2);
        check("emg_ns111", 32'(ns_light), 32'h4);
        check("emg_ew111", 32'(ew_light), 32'h4);
        step(3);
        check("emg_cd114", 32'(countdown_time), 32'd2);
        step(1);
        check("emg_cd115", 32'(countdown_time), 32'd1);
        step(4);
        check("emg_cd119", 32'(countdown_time), 32'd16);
        check("emg_ns119", 32'(ns_light), 32'h1);
        check("emg_ew119", 32'(ew_light), 32'h4);

        // Pedestrian and emergency in the same cycle
        ped_req   = 1'b1;
        emergency = 1'b1;
        step(1);
        ped_req = 1'b0;
        check("both_cd120", 32'(countdown_time), 32'd0);
        check("both_pp120", 32'(ped_pending), 32'd0);
        step(2);
        check("both_pp122", 32'(ped_pending), 32'd0);
        emergency = 1'b0;
        step(1);
        check("both_cd123", 32'(countdown_time), 32'd2);
        check("both_pp123", 32'(ped_pending), 32'd0);

        // Asynchronous reset mid NS yellow
        do_reset();
        step(65);
        check("ar_ns65", 32'(ns_light), 32'h2);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        check("ar_pp66", 32'(ped_pending), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_ns", 32'(ns_light), 32'h1);
        check("ar_ew", 32'(ew_light), 32'h4);
        check("ar_cd", 32'(countdown_time), 32'd16);
        check("ar_pp", 32'(ped_pending), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3);
        check("ar_cd3", 32'(countdown_time), 32'd16);
        step(1);
        check("ar_cd4", 32'(countdown_time), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Sequencing controller for a two-direction (north-south / east-west) intersection. A prescaled one-second tick drives a six-state light cycle and a down-counter of remaining seconds. The counter is exported as `countdown_time` to the seven-segment countdown display block. The block also takes a pedestrian request, which shortens the active green, and an emergency override, which forces all directions to red.

## Interface
Parameters:
- `CLK_DIV`, 32'd2000: `clk` cycles per second tick. Legal range is ≥ 2.
- `GREEN_TIME`, 5'd16: green duration in seconds. Legal range is 1..16.
- `YELLOW_TIME`, 5'd3: yellow duration in seconds. Legal range is 1..16.
- `ALLRED_TIME`, 5'd2: all-red clearance in seconds. Legal range is 1..16.
- `PED_TIME`, 5'd5: remaining green after a pedestrian request. Legal range is 1..GREEN_TIME.

Ports:
- `clk`  in  1  system clock. The block has one clock; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `ped_req`  in  1  pedestrian request, synchronous level; any high cycle registers a request.
- `emergency`  in  1  emergency override, synchronous level, active high.
- `ns_light`  out  3  {red, yellow, green} for north-south; exactly one bit high.
- `ew_light`  out  3  {red, yellow, green} for east-west; exactly one bit high.
- `countdown_time`  out  5  remaining seconds in the current state; 0 in EMERG. Range is 0..16.
- `ped_pending`  out  1  a registered pedestrian request has not yet been serviced.

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick` is high for one cycle when `div_cnt == CLK_DIV-1`.
- States, lights and durations (ns / ew):
  - NS_GREEN: green / red, for GREEN_TIME.
  - NS_YELLOW: yellow / red, for YELLOW_TIME.
  - ALLRED_B: red / red, for ALLRED_TIME.
  - EW_GREEN: red / green, for GREEN_TIME.
  - EW_YELLOW: red / yellow, for YELLOW_TIME.
  - ALLRED_A: red / red, for ALLRED_TIME.
  - EMERG: red / red, with no duration.
- Normal cycle: NS_GREEN → NS_YELLOW → ALLRED_B → EW_GREEN → EW_YELLOW → ALLRED_A → NS_GREEN.
- On state entry, `countdown_time` loads that state's duration.
- On `tick` with `countdown_time == 1`, the block advances to the next state and loads the next duration.
- On any other `tick`, `countdown_time` decrements by 1. The displayed sequence is therefore duration, duration-1, …, 1.
- Pedestrian request:
  - `ped_pending` sets on any cycle with `ped_req` = 1.
  - It clears on entry to NS_YELLOW, EW_YELLOW or EMERG. If a clear and a set occur in the same cycle, set wins.
  - On `tick` in NS_GREEN or EW_GREEN with `ped_pending` = 1 and `countdown_time` > PED_TIME, `countdown_time` loads PED_TIME instead of decrementing.
  - Otherwise the normal decrement/advance rule applies.
  - No effect in yellow or all-red states; the request stays pending until the next yellow.
- Emergency override:
  - `emergency` = 1 in any state forces EMERG on the next edge, with `countdown_time` = 0.
  - In EMERG, `div_cnt` is held at 0 and `ped_pending` is cleared.
  - Emergency has priority over `tick` and over the pedestrian request.
  - While `emergency` is high, the block stays in EMERG.
  - On the first cycle with `emergency` = 0, the block enters ALLRED_A with `countdown_time` = ALLRED_TIME, and `div_cnt` restarts from 0.
- Arithmetic: `countdown_time` is 5-bit unsigned. It never decrements below 1 outside EMERG and never exceeds 16.

## Timing
- Reset (`rst_n` low, asynchronous) sets:
  - state NS_GREEN, `div_cnt` 0, `countdown_time` = GREEN_TIME.
  - `ns_light` 3'b001, `ew_light` 3'b100, `ped_pending` 0.
- All outputs are registered and change only on the rising `clk` edge; state and lights update on the same edge.
- The first `tick` occurs CLK_DIV cycles after reset release, i.e. when `div_cnt` first reaches CLK_DIV-1.
- Each state lasts duration × CLK_DIV cycles, except:
  - the first state after EMERG exit, which has the same length counted from exit;
  - a pedestrian-shortened green.
- The full normal cycle is (2·GREEN_TIME + 2·YELLOW_TIME + 2·ALLRED_TIME) × CLK_DIV cycles. With default durations and CLK_DIV = 4 this is 168 cycles.
- `emergency` rising to EMERG has 1-cycle latency. EMERG exit to ALLRED_A has 1-cycle latency.
- Reset asserted mid-cycle or in EMERG returns the block to the reset values immediately. No state survives reset.

## Test plan
Bench uses CLK_DIV = 4 and default durations.
- Release reset, idle for 168 cycles → state sequence NS_GREEN (64 cycles), NS_YELLOW (12), ALLRED_B (8), EW_GREEN (64), EW_YELLOW (12), ALLRED_A (8). `countdown_time` steps 16..1, 3..1, 2..1 in each pair of directions. Lights are always one-hot.
- Pulse `ped_req` for 1 cycle at cycle 10 (`countdown_time` = 14) → `ped_pending` = 1. At the tick at cycle 12, `countdown_time` = 5. NS_YELLOW is entered at cycle 32 and `ped_pending` clears there.
- Pulse `ped_req` when `countdown_time` = 3 in EW_GREEN → no reload; count continues 2, 1, then EW_YELLOW. `ped_pending` clears on EW_YELLOW entry.
- Assert `emergency` for 20 cycles during EW_GREEN → next edge gives `ns_light` = `ew_light` = 3'b100 and `countdown_time` = 0. After release: ALLRED_A with `countdown_time` 2 for 8 cycles, then NS_GREEN with 16.
- Assert `ped_req` and `emergency` in the same cycle → EMERG entered and `ped_pending` = 0 after the override.
- Assert `rst_n` low mid-NS_YELLOW, asynchronously between edges → outputs immediately show NS_GREEN, `countdown_time` 16, `ped_pending` 0. The first tick comes 4 cycles after release.
